// File: rtl/vip_ycbcr444_ycbcr422_pkg.sv
// Shared definitions for the 4:4:4 -> 4:2:2 packer: component width, packed-word
// layout ({chroma, luma}) and the rounding chroma average.
package vip_ycbcr444_ycbcr422_pkg;

  localparam int COMP_W     = 8;
  localparam int WORD_W     = 2 * COMP_W;
  localparam int CHROMA_MSB = WORD_W - 1;
  localparam int CHROMA_LSB = COMP_W;
  localparam int LUMA_MSB   = COMP_W - 1;
  localparam int LUMA_LSB   = 0;

  typedef logic [COMP_W-1:0] comp_t;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    PHASE_EVEN = 1'b0,
    PHASE_ODD  = 1'b1
  } phase_e;

  // One extra bit of headroom so 255+255+1 does not wrap before the halving.
  function automatic comp_t chroma_avg(input comp_t a, input comp_t b);
    logic [COMP_W:0] sum;
    sum = {1'b0, a} + {1'b0, b} + {{COMP_W{1'b0}}, 1'b1};
    return comp_t'(sum >> 1);
  endfunction

  function automatic word_t pack_word(input comp_t chroma, input comp_t luma);
    word_t w;
    w = '0;
    w[CHROMA_MSB:CHROMA_LSB] = chroma;
    w[LUMA_MSB:LUMA_LSB]     = luma;
    return w;
  endfunction

endpackage

// File: rtl/vip_sync_delay.sv
// N-stage delay line for the vsync/href/clken sync triple, shared by VIP blocks
// whose data path is N clocks deep.
module vip_sync_delay #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  input  logic href,
  input  logic clken,
  output logic vsync_dly,
  output logic href_dly,
  output logic clken_dly
);

  logic [2:0] stage [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) stage[i] <= '0;
    end else begin
      stage[0] <= {vsync, href, clken};
      for (int i = 1; i < N; i++) stage[i] <= stage[i-1];
    end
  end

  assign {vsync_dly, href_dly, clken_dly} = stage[N-1];

endmodule

// File: rtl/vip_ycbcr444_ycbcr422.sv
// Packs 4:4:4 YCbCr pixels into 16-bit 4:2:2 words: {Cb,Y} on even pixels and
// {Cr,Y} on odd pixels, chroma averaged (or decimated) over each pixel pair.
module vip_ycbcr444_ycbcr422
  import vip_ycbcr444_ycbcr422_pkg::*;
#(
  parameter int AVG_EN = 1,
  parameter int LAG    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic [7:0]  per_img_Y,
  input  logic [7:0]  per_img_Cb,
  input  logic [7:0]  per_img_Cr,
  output logic        post_frame_vsync,
  output logic        post_frame_href,
  output logic        post_frame_clken,
  output logic [15:0] post_frame_YCbCr
);

  // The data path is structurally two registers deep; LAG only documents that.
  localparam int SYNC_LAG = (LAG == 2) ? LAG : 2;

  logic   pix;
  logic   even_pix;
  logic   odd_pix;
  logic   trail;
  phase_e phase;
  comp_t  y0;
  comp_t  cb0;
  comp_t  cr0;
  comp_t  cb_p;
  comp_t  cr_p;
  word_t  hold_word;
  logic   odd_pend;
  word_t  data_word;

  vip_sync_delay #(
    .N(SYNC_LAG)
  ) u_sync_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .vsync     (per_frame_vsync),
    .href      (per_frame_href),
    .clken     (per_frame_clken),
    .vsync_dly (post_frame_vsync),
    .href_dly  (post_frame_href),
    .clken_dly (post_frame_clken)
  );

  always_comb begin
    pix      = per_frame_href & per_frame_clken;
    even_pix = pix && (phase == PHASE_EVEN);
    odd_pix  = pix && (phase == PHASE_ODD);
    // An even pixel left without a partner at the end of an odd-length line.
    trail    = !pix && (phase == PHASE_ODD);
    if (AVG_EN != 0) begin
      cb_p = chroma_avg(cb0, per_img_Cb);
      cr_p = chroma_avg(cr0, per_img_Cr);
    end else begin
      cb_p = cb0;
      cr_p = cr0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= PHASE_EVEN;
      y0        <= '0;
      cb0       <= '0;
      cr0       <= '0;
      hold_word <= '0;
      odd_pend  <= 1'b0;
      data_word <= '0;
    end else begin
      if (even_pix) begin
        y0  <= per_img_Y;
        cb0 <= per_img_Cb;
        cr0 <= per_img_Cr;
      end
      if (odd_pix) begin
        hold_word <= pack_word(cr_p, per_img_Y);
      end
      odd_pend <= odd_pix;

      // Only a pending even pixel leaves the pair open; href low, an odd pixel
      // or a trailing flush all return to EVEN so each line opens with Cb.
      phase <= even_pix ? PHASE_ODD : PHASE_EVEN;

      // The held Cr word always goes out the edge after its pair completes,
      // alongside the next even pixel's latch.
      if (odd_pend) begin
        data_word <= hold_word;
      end else if (odd_pix) begin
        data_word <= pack_word(cb_p, y0);
      end else if (trail) begin
        data_word <= pack_word(cb0, y0);
      end else begin
        data_word <= '0;
      end
    end
  end

  assign post_frame_YCbCr = data_word;

endmodule
